// File: rtl/memory_stage.sv
// memory_stage: pipeline MEM stage between the execute register and writeback.
//
// Turns a load/store from execute into a data-bus request, holds it across a
// variable-latency valid/data_ok handshake and stalls upstream while it waits.
// Store data and strobes are lane-aligned to the 8-byte word; load data is
// extracted from its lane and sign/zero-extended. Accesses below MMIO_BOUND
// are flagged with skip. Non-memory instructions pass through in one cycle.
//
// Handshake: while state is BUSY, dreq_valid is high and addr/size/strobe/data
// stay constant; the request completes in the cycle dresp_data_ok is high
// (single-cycle pulse). dataE is consumed only in a cycle where stall_o is low
// and dataE.valid is high.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   dataE   [236:0] execute_data_t, packed MSB first:
//                   {valid, raw_instr[31:0], pc[63:0], regwrite, memtoreg,
//                    memread, memwrite, msize[1:0], mem_unsigned, dst[4:0],
//                    aluout[63:0], writedata[63:0]}
//   stall_o         high: upstream must hold dataE
//   dataM   [232:0] memory_data_t, packed MSB first:
//                   {valid, raw_instr[31:0], pc[63:0], regwrite, memtoreg,
//                    dst[4:0], aluout[63:0], readdata[63:0], skip}
//   dreq_valid      data request valid
//   dreq_addr       request address (aluout unmodified)
//   dreq_size       msize_t: 0=1B, 1=2B, 2=4B, 3=8B
//   dreq_strobe     byte write enables, 0 for loads
//   dreq_data       lane-aligned store data
//   dresp_data_ok   response / write completion pulse
//   dresp_data      read data in byte lanes of the aligned 8-byte word

module memory_stage #(
    parameter logic [63:0] MMIO_BOUND = 64'h8000_0000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [236:0] dataE,
    output logic         stall_o,
    output logic [232:0] dataM,
    output logic         dreq_valid,
    output logic [63:0]  dreq_addr,
    output logic [1:0]   dreq_size,
    output logic [7:0]   dreq_strobe,
    output logic [63:0]  dreq_data,
    input  logic         dresp_data_ok,
    input  logic [63:0]  dresp_data
);

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_BUSY = 1'b1;

    localparam logic [1:0] MSIZE1 = 2'd0;
    localparam logic [1:0] MSIZE2 = 2'd1;
    localparam logic [1:0] MSIZE4 = 2'd2;
    localparam logic [1:0] MSIZE8 = 2'd3;

    // Unpacked execute fields
    logic        e_valid;
    logic [31:0] e_raw_instr;
    logic [63:0] e_pc;
    logic        e_regwrite;
    logic        e_memtoreg;
    logic        e_memread;
    logic        e_memwrite;
    logic [1:0]  e_msize;
    logic        e_mem_unsigned;
    logic [4:0]  e_dst;
    logic [63:0] e_aluout;
    logic [63:0] e_writedata;

    assign {e_valid, e_raw_instr, e_pc, e_regwrite, e_memtoreg, e_memread,
            e_memwrite, e_msize, e_mem_unsigned, e_dst, e_aluout,
            e_writedata} = dataE;

    logic [0:0] state;

    // Latched request context
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic [7:0]  req_strobe;
    logic [63:0] req_data;
    logic        req_unsigned;
    logic        req_store;
    logic        req_regwrite;
    logic        req_memtoreg;
    logic [4:0]  req_dst;
    logic [63:0] req_pc;
    logic [31:0] req_raw_instr;

    // Registered writeback fields
    logic        m_valid;
    logic [31:0] m_raw_instr;
    logic [63:0] m_pc;
    logic        m_regwrite;
    logic        m_memtoreg;
    logic [4:0]  m_dst;
    logic [63:0] m_aluout;
    logic [63:0] m_readdata;
    logic        m_skip;

    assign dataM = {m_valid, m_raw_instr, m_pc, m_regwrite, m_memtoreg,
                    m_dst, m_aluout, m_readdata, m_skip};

    assign stall_o     = (state == STATE_BUSY);
    assign dreq_valid  = (state == STATE_BUSY);
    assign dreq_addr   = req_addr;
    assign dreq_size   = req_size;
    assign dreq_strobe = req_strobe;
    assign dreq_data   = req_data;

    logic        e_is_mem;
    logic [2:0]  e_offset;
    logic [7:0]  st_strobe;
    logic [63:0] st_data;

    assign e_is_mem = e_memread | e_memwrite;
    assign e_offset = e_aluout[2:0];

    // Store lane alignment, computed from execute and captured at acceptance
    // so the request is stable for the whole BUSY window.
    always_comb begin
        st_strobe = 8'h00;
        case (e_msize)
            MSIZE1:  st_strobe = 8'h01 << e_offset;
            MSIZE2:  st_strobe = 8'h03 << e_offset;
            MSIZE4:  st_strobe = 8'h0F << e_offset;
            MSIZE8:  st_strobe = 8'hFF;
            default: st_strobe = 8'h00;
        endcase
        if (!e_memwrite) begin
            st_strobe = 8'h00;
        end
        st_data = e_writedata << {e_offset, 3'b000};
    end

    logic [63:0] ld_shifted;
    logic [63:0] ld_value;

    // Load extraction from the response lane of the latched address.
    always_comb begin
        ld_shifted = dresp_data >> {req_addr[2:0], 3'b000};
        ld_value   = 64'd0;
        case (req_size)
            MSIZE1: ld_value = req_unsigned ? {56'd0, ld_shifted[7:0]}
                                            : {{56{ld_shifted[7]}}, ld_shifted[7:0]};
            MSIZE2: ld_value = req_unsigned ? {48'd0, ld_shifted[15:0]}
                                            : {{48{ld_shifted[15]}}, ld_shifted[15:0]};
            MSIZE4: ld_value = req_unsigned ? {32'd0, ld_shifted[31:0]}
                                            : {{32{ld_shifted[31]}}, ld_shifted[31:0]};
            MSIZE8: ld_value = ld_shifted;
            default: ld_value = 64'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= STATE_IDLE;
            req_addr      <= 64'd0;
            req_size      <= 2'd0;
            req_strobe    <= 8'd0;
            req_data      <= 64'd0;
            req_unsigned  <= 1'b0;
            req_store     <= 1'b0;
            req_regwrite  <= 1'b0;
            req_memtoreg  <= 1'b0;
            req_dst       <= 5'd0;
            req_pc        <= 64'd0;
            req_raw_instr <= 32'd0;
            m_valid       <= 1'b0;
            m_raw_instr   <= 32'd0;
            m_pc          <= 64'd0;
            m_regwrite    <= 1'b0;
            m_memtoreg    <= 1'b0;
            m_dst         <= 5'd0;
            m_aluout      <= 64'd0;
            m_readdata    <= 64'd0;
            m_skip        <= 1'b0;
        end else begin
            // valid is a one-cycle pulse per completed instruction
            m_valid <= 1'b0;
            case (state)
                STATE_IDLE: begin
                    // a stray data_ok here is ignored
                    if (e_valid) begin
                        if (e_is_mem) begin
                            state         <= STATE_BUSY;
                            req_addr      <= e_aluout;
                            req_size      <= e_msize;
                            req_strobe    <= st_strobe;
                            req_data      <= st_data;
                            req_unsigned  <= e_mem_unsigned;
                            req_store     <= e_memwrite;
                            req_regwrite  <= e_regwrite;
                            req_memtoreg  <= e_memtoreg;
                            req_dst       <= e_dst;
                            req_pc        <= e_pc;
                            req_raw_instr <= e_raw_instr;
                        end else begin
                            m_valid     <= 1'b1;
                            m_raw_instr <= e_raw_instr;
                            m_pc        <= e_pc;
                            m_regwrite  <= e_regwrite;
                            m_memtoreg  <= e_memtoreg;
                            m_dst       <= e_dst;
                            m_aluout    <= e_aluout;
                            m_readdata  <= 64'd0;
                            m_skip      <= 1'b0;
                        end
                    end
                end
                STATE_BUSY: begin
                    if (dresp_data_ok) begin
                        state       <= STATE_IDLE;
                        m_valid     <= 1'b1;
                        m_raw_instr <= req_raw_instr;
                        m_pc        <= req_pc;
                        m_regwrite  <= req_regwrite;
                        m_memtoreg  <= req_memtoreg;
                        m_dst       <= req_dst;
                        m_aluout    <= req_addr;
                        m_readdata  <= req_store ? 64'd0 : ld_value;
                        m_skip      <= (req_addr < MMIO_BOUND);
                    end
                end
                default: state <= STATE_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed test-plan cases plus randomized load/store/ALU
// traffic for memory_stage, checked against a byte-lane reference model.

module tb_memory_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] raw_instr;
        logic [63:0] pc;
        logic        regwrite;
        logic        memtoreg;
        logic        memread;
        logic        memwrite;
        logic [1:0]  msize;
        logic        mem_unsigned;
        logic [4:0]  dst;
        logic [63:0] aluout;
        logic [63:0] writedata;
    } ex_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] raw_instr;
        logic [63:0] pc;
        logic        regwrite;
        logic        memtoreg;
        logic [4:0]  dst;
        logic [63:0] aluout;
        logic [63:0] readdata;
        logic        skip;
    } mem_t;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    ex_t         dataE;
    logic        stall_o;
    mem_t        dataM;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [1:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk           (clk),
        .reset         (reset),
        .dataE         (dataE),
        .stall_o       (stall_o),
        .dataM         (dataM),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data)
    );

    // ---------------- scoreboard ----------------
    int   tests = 0;
    int   fails = 0;
    mem_t exp_q[$];
    mem_t last_m;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] model_strobe(input ex_t e);
        int          bytes;
        logic [15:0] m;
        if (!e.memwrite) return 8'h00;
        bytes = 1 << e.msize;
        if (bytes == 8) return 8'hFF;
        m = (16'd1 << bytes) - 16'd1;
        m = m << e.aluout[2:0];
        return m[7:0];
    endfunction

    function automatic logic [63:0] model_wdata(input ex_t e);
        return e.writedata << (8 * int'(e.aluout[2:0]));
    endfunction

    function automatic logic [63:0] model_load(input ex_t e, input logic [63:0] resp);
        int          nbits;
        logic [63:0] t;
        logic [63:0] mask;
        logic [63:0] field;
        t     = resp >> (8 * int'(e.aluout[2:0]));
        nbits = 8 << e.msize;
        if (nbits == 64) return t;
        mask  = (64'd1 << nbits) - 64'd1;
        field = t & mask;
        if (!e.mem_unsigned && field[nbits-1]) field = field | ~mask;
        return field;
    endfunction

    function automatic mem_t model_result(input ex_t e, input logic [63:0] resp);
        mem_t r;
        logic is_mem;
        is_mem      = e.memread | e.memwrite;
        r.valid     = 1'b1;
        r.raw_instr = e.raw_instr;
        r.pc        = e.pc;
        r.regwrite  = e.regwrite;
        r.memtoreg  = e.memtoreg;
        r.dst       = e.dst;
        r.aluout    = e.aluout;
        r.readdata  = (is_mem && !e.memwrite) ? model_load(e, resp) : 64'd0;
        r.skip      = is_mem && (e.aluout < 64'h8000_0000);
        return r;
    endfunction

    function automatic ex_t mk(input logic rd, input logic wr, input logic [1:0] sz,
                               input logic uns, input logic [63:0] addr,
                               input logic [63:0] wdata, input logic [4:0] dst);
        ex_t e;
        e.valid        = 1'b1;
        e.raw_instr    = 32'($urandom());
        e.pc           = {32'h0000_0000, 32'($urandom())};
        e.regwrite     = ~wr;
        e.memtoreg     = rd;
        e.memread      = rd;
        e.memwrite     = wr;
        e.msize        = sz;
        e.mem_unsigned = uns;
        e.dst          = dst;
        e.aluout       = addr;
        e.writedata    = wdata;
        return e;
    endfunction

    // ---------------- driver ----------------
    // Called at a negedge. Presents e, runs the handshake with data_ok on the
    // k-th BUSY cycle, and checks the writeback one cycle later.
    task automatic run_op(input ex_t e, input int k, input logic [63:0] resp);
        ex_t junk;
        logic is_mem;
        is_mem = e.memread | e.memwrite;
        exp_q.push_back(model_result(e, resp));
        dataE = e;
        @(posedge clk);
        @(negedge clk);
        dataE = '0;
        if (is_mem) begin
            for (int i = 1; i <= k; i++) begin
                check("stall_busy",  256'(stall_o), 256'(1'b1));
                check("dreq_valid",  256'(dreq_valid), 256'(1'b1));
                check("dreq_addr",   256'(dreq_addr), 256'(e.aluout));
                check("dreq_size",   256'(dreq_size), 256'(e.msize));
                check("dreq_strobe", 256'(dreq_strobe), 256'(model_strobe(e)));
                if (e.memwrite) check("dreq_data", 256'(dreq_data), 256'(model_wdata(e)));
                check("dataM_idle_busy", 256'(dataM.valid), 256'(1'b0));
                // upstream offers a new instruction that must not be consumed
                junk = mk(1'b0, 1'b0, 2'd0, 1'b0, 64'($urandom()), 64'd0, 5'd1);
                dataE = junk;
                if (i == k) begin
                    dresp_data_ok = 1'b1;
                    dresp_data    = resp;
                end
                @(posedge clk);
                @(negedge clk);
                dataE         = '0;
                dresp_data_ok = 1'b0;
                dresp_data    = {32'($urandom()), 32'($urandom())};
            end
        end
        check("stall_done", 256'(stall_o), 256'(1'b0));
        check("dreq_idle",  256'(dreq_valid), 256'(1'b0));
        last_m = dataM;
        if (exp_q.size() == 0) begin
            check("dataM_unexpected", 256'(dataM.valid), 256'(1'b0));
        end else begin
            check("dataM", 256'(dataM), 256'(exp_q.pop_front()));
        end
    endtask

    task automatic idle_cycle();
        dataE = '0;
        @(posedge clk);
        @(negedge clk);
        check("dataM_pulse", 256'(dataM.valid), 256'(1'b0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        ex_t  e;
        logic [31:0] hi;
        int   kind;

        reset         = 1'b1;
        dataE         = '0;
        dresp_data_ok = 1'b0;
        dresp_data    = 64'd0;
        @(negedge clk);
        @(negedge clk);
        check("rst_dataM",  256'(dataM), 256'(0));
        check("rst_dreq",   256'(dreq_valid), 256'(1'b0));
        check("rst_stall",  256'(stall_o), 256'(1'b0));
        check("rst_strobe", 256'(dreq_strobe), 256'(0));
        check("rst_addr",   256'(dreq_addr), 256'(0));
        check("rst_data",   256'(dreq_data), 256'(0));
        reset = 1'b0;
        @(negedge clk);

        // Pass-through ADD
        e = mk(1'b0, 1'b0, 2'd3, 1'b0, 64'h1234, 64'h0, 5'd5);
        run_op(e, 0, 64'd0);
        check("add_valid",  256'(last_m.valid), 256'(1'b1));
        check("add_aluout", 256'(last_m.aluout), 256'(64'h1234));
        check("add_dst",    256'(last_m.dst), 256'(5'd5));
        idle_cycle();

        // LB signed, 3 BUSY cycles
        e = mk(1'b1, 1'b0, 2'd0, 1'b0, 64'h8000_0003, 64'h0, 5'd7);
        run_op(e, 3, 64'h0000_0000_8000_0000);
        check("lb_readdata", 256'(last_m.readdata), 256'(64'hFFFF_FFFF_FFFF_FF80));
        check("lb_skip",     256'(last_m.skip), 256'(1'b0));

        // LHU
        e = mk(1'b1, 1'b0, 2'd1, 1'b1, 64'h8000_0006, 64'h0, 5'd8);
        run_op(e, 2, 64'hBEEF_0000_0000_0000);
        check("lhu_readdata", 256'(last_m.readdata), 256'(64'h0000_0000_0000_BEEF));

        // SW, data_ok on first request cycle
        e = mk(1'b0, 1'b1, 2'd2, 1'b0, 64'h8000_0004, 64'hDEADBEEF, 5'd0);
        dataE = e;
        exp_q.push_back(model_result(e, 64'd0));
        @(posedge clk);
        @(negedge clk);
        dataE = '0;
        check("sw_strobe", 256'(dreq_strobe), 256'(8'hF0));
        check("sw_data",   256'(dreq_data), 256'(64'hDEADBEEF_0000_0000));
        check("sw_stall",  256'(stall_o), 256'(1'b1));
        dresp_data_ok = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dresp_data_ok = 1'b0;
        check("sw_stall_end", 256'(stall_o), 256'(1'b0));
        check("sw_valid",     256'(dataM.valid), 256'(1'b1));
        check("sw_readdata",  256'(dataM.readdata), 256'(0));
        check("sw_dataM",     256'(dataM), 256'(exp_q.pop_front()));
        idle_cycle();

        // MMIO skip
        e = mk(1'b1, 1'b0, 2'd3, 1'b0, 64'h4000_0000, 64'h0, 5'd9);
        run_op(e, 1, 64'h0123_4567_89AB_CDEF);
        check("mmio_skip", 256'(last_m.skip), 256'(1'b1));
        e = mk(1'b1, 1'b0, 2'd3, 1'b0, 64'h8000_0000, 64'h0, 5'd9);
        run_op(e, 1, 64'h0123_4567_89AB_CDEF);
        check("mem_skip", 256'(last_m.skip), 256'(1'b0));

        // Reset in the middle of a load
        e = mk(1'b1, 1'b0, 2'd2, 1'b0, 64'h8000_0010, 64'h0, 5'd3);
        dataE = e;
        @(posedge clk);
        @(negedge clk);
        dataE = '0;
        check("rmid_busy", 256'(stall_o), 256'(1'b1));
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rmid_dreq",  256'(dreq_valid), 256'(1'b0));
        check("rmid_stall", 256'(stall_o), 256'(1'b0));
        @(negedge clk);
        reset         = 1'b0;
        dresp_data_ok = 1'b1;
        dresp_data    = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        dresp_data_ok = 1'b0;
        check("rmid_no_valid", 256'(dataM.valid), 256'(1'b0));
        check("rmid_idle",     256'(stall_o), 256'(1'b0));
        idle_cycle();

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 2);
            hi   = $urandom_range(0, 1) ? 32'h0 : 32'($urandom());
            e = mk(kind == 1, kind == 2, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   {hi, 32'($urandom())}, {32'($urandom()), 32'($urandom())},
                   5'($urandom_range(0, 31)));
            run_op(e, $urandom_range(1, 4), {32'($urandom()), 32'($urandom())});
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end

        check("queue_empty", 256'(exp_q.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
